// File: rtl/if_pc_stage.sv
// Instruction-fetch PC stage: owns the PC register, issues instruction
// memory requests, and delivers (instruction, PC+1) pairs to the DOF stage.
// A one-entry holding buffer catches a word that returns while the
// downstream stage is stalled, so no acknowledged instruction is lost.
module if_pc_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic [15:0] ir_out,
  output logic [15:0] pc1_out,
  output logic        ir_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t      state;
  logic [15:0] hbuf;
  logic [15:0] hbuf_pc1;

  // Address and incrementer are pure functions of the PC register; the
  // 16-bit sum drops the carry so 16'hFFFF wraps to 16'h0000.
  assign pc_plus1  = pc + 16'd1;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH);

  // Fetch control: redirect beats stall and ack; the PC only advances when
  // the word at the current address has been captured (IR or hbuf) or is
  // being thrown away by a redirect, which keeps imem_addr stable while a
  // request is outstanding.
  always_ff @(posedge clk) begin
    // NOTE: every register here, including the holding buffer, is cleared
    // by the synchronous reset so a word parked in hbuf can never leak out
    // after reset; all state uses non-blocking assignments so each branch
    // sees the pre-edge values of pc, pc_plus1 and hbuf.
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir_out   <= 16'h0000;
      pc1_out  <= 16'h0000;
      ir_valid <= 1'b0;
      hbuf     <= 16'h0000;
      hbuf_pc1 <= 16'h0000;
    end else if (redirect) begin
      // Any word acknowledged now, and anything parked in hbuf, is dropped
      // simply by not copying it anywhere and leaving HOLD.
      pc       <= pc_next;
      ir_valid <= 1'b0;
      state    <= FETCH;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end

        FETCH: begin
          if (stall) begin
            // IR outputs frozen; an arriving word is parked for later.
            if (imem_ack) begin
              hbuf     <= imem_rdata;
              hbuf_pc1 <= pc_plus1;
              pc       <= pc_next;
              state    <= HOLD;
            end
          end else if (imem_ack) begin
            ir_out   <= imem_rdata;
            pc1_out  <= pc_plus1;
            ir_valid <= 1'b1;
            pc       <= pc_next;
          end else begin
            // Wait state: insert a bubble and keep requesting the same PC.
            ir_valid <= 1'b0;
          end
        end

        HOLD: begin
          // No request is issued here; the parked word goes out as soon as
          // the stall clears, then fetching resumes at the advanced PC.
          if (!stall) begin
            ir_out   <= hbuf;
            pc1_out  <= hbuf_pc1;
            ir_valid <= 1'b1;
            state    <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed bench for if_pc_stage. A second instance with RESET_PC=16'hFFFF
// shares the memory/control inputs to exercise PC wrap-around.
module tb_if_pc_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_next;
  logic [15:0] pc_next_w;
  logic        redirect;
  logic        stall;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  logic        imem_req,  imem_req_w;
  logic [15:0] imem_addr, imem_addr_w;
  logic [15:0] pc,        pc_w;
  logic [15:0] pc_plus1,  pc_plus1_w;
  logic [15:0] ir_out,    ir_out_w;
  logic [15:0] pc1_out,   pc1_out_w;
  logic        ir_valid,  ir_valid_w;

  int n_checks = 0;
  int n_fail   = 0;

  if_pc_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .redirect(redirect),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
    .pc_plus1(pc_plus1), .ir_out(ir_out), .pc1_out(pc1_out),
    .ir_valid(ir_valid)
  );

  if_pc_stage #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next_w), .redirect(redirect),
    .stall(stall), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc_w),
    .pc_plus1(pc_plus1_w), .ir_out(ir_out_w), .pc1_out(pc1_out_w),
    .ir_valid(ir_valid_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all controls for the next edge in one call.
  task automatic drive(input logic r, input logic s, input logic a,
                       input logic [15:0] d, input logic [15:0] nx);
    redirect   = r;
    stall      = s;
    imem_ack   = a;
    imem_rdata = d;
    pc_next    = nx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h1111);
    pc_next_w = 16'h0000;
    tick();
    tick();
    n_checks++; if (pc !== 16'h0000)    begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
    n_checks++; if (ir_out !== 16'h0000) begin n_fail++; $display("FAIL reset_ir got %h want 0000", ir_out); end
    n_checks++; if (pc1_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc1 got %h want 0000", pc1_out); end
    n_checks++; if (ir_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b want 0", ir_valid); end
    n_checks++; if (imem_req !== 1'b0)  begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_checks++; if (pc_w !== 16'hFFFF)  begin n_fail++; $display("FAIL reset_pc_w got %h want ffff", pc_w); end
    n_checks++; if (pc_plus1_w !== 16'h0000) begin n_fail++; $display("FAIL wrap_plus1 got %h want 0000", pc_plus1_w); end
    // Release reset: first cycle is IDLE (no request), second is FETCH.
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b want 0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1)      begin n_fail++; $display("FAIL first_req got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_addr got %h want 0000", imem_addr); end
    n_checks++; if (ir_valid !== 1'b0)      begin n_fail++; $display("FAIL idle_valid got %b want 0", ir_valid); end
  endtask

  task automatic test_stream();
    logic [15:0] exp_ir [3];
    exp_ir[0] = 16'hA5A5;
    exp_ir[1] = 16'hA5A4;
    exp_ir[2] = 16'hA5A7;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'(i) ^ 16'hA5A5, 16'(i + 1));
      tick();
      n_checks++; if (ir_out !== exp_ir[i])   begin n_fail++; $display("FAIL stream_ir[%0d] got %h want %h", i, ir_out, exp_ir[i]); end
      n_checks++; if (pc1_out !== 16'(i + 1)) begin n_fail++; $display("FAIL stream_pc1[%0d] got %h want %h", i, pc1_out, 16'(i + 1)); end
      n_checks++; if (ir_valid !== 1'b1)      begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", i, ir_valid); end
      if (i == 0) begin
        n_checks++; if (ir_valid_w !== 1'b1 || pc1_out_w !== 16'h0000 || ir_out_w !== 16'hA5A5)
          begin n_fail++; $display("FAIL wrap_first got v=%b pc1=%h ir=%h want v=1 pc1=0000 ir=a5a5", ir_valid_w, pc1_out_w, ir_out_w); end
      end
    end
    n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL stream_pc got %h want 0003", pc); end
  endtask

  task automatic test_stall_ack();
    drive(1'b0, 1'b1, 1'b1, 16'h1234, 16'h0004);
    tick();
    n_checks++; if (pc !== 16'h0004) begin n_fail++; $display("FAIL stall_pc got %h want 0004", pc); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ir_out !== 16'hA5A7 || ir_valid !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold[%0d] got ir=%h v=%b want ir=a5a7 v=1", i, ir_out, ir_valid); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); end
      if (i < 2) begin
        drive(1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h0099);
        tick();
      end
    end
    drive(1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0099);
    tick();
    n_checks++; if (ir_out !== 16'h1234 || pc1_out !== 16'h0004 || ir_valid !== 1'b1)
      begin n_fail++; $display("FAIL hold_issue got ir=%h pc1=%h v=%b want 1234 0004 1", ir_out, pc1_out, ir_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004)
      begin n_fail++; $display("FAIL hold_resume got req=%b addr=%h want 1 0004", imem_req, imem_addr); end
    drive(1'b0, 1'b0, 1'b1, 16'h0004 ^ 16'hA5A5, 16'h0005);
    tick();
    n_checks++; if (ir_out !== 16'hA5A1 || pc1_out !== 16'h0005 || ir_valid !== 1'b1)
      begin n_fail++; $display("FAIL after_hold got ir=%h pc1=%h v=%b want a5a1 0005 1", ir_out, pc1_out, ir_valid); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'hCCCC, 16'h0077);
      tick();
      n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid[%0d] got %b want 0", i, ir_valid); end
      n_checks++; if (imem_addr !== 16'h0005 || imem_req !== 1'b1)
        begin n_fail++; $display("FAIL wait_addr[%0d] got addr=%h req=%b want 0005 1", i, imem_addr, imem_req); end
    end
    drive(1'b0, 1'b0, 1'b1, 16'h0005 ^ 16'hA5A5, 16'h0006);
    tick();
    n_checks++; if (ir_out !== 16'hA5A0 || pc1_out !== 16'h0006 || ir_valid !== 1'b1)
      begin n_fail++; $display("FAIL wait_done got ir=%h pc1=%h v=%b want a5a0 0006 1", ir_out, pc1_out, ir_valid); end
    // Stall without ack: everything holds, request stays up.
    drive(1'b0, 1'b1, 1'b0, 16'hCCCC, 16'h0077);
    tick();
    n_checks++; if (pc !== 16'h0006 || imem_req !== 1'b1 || ir_out !== 16'hA5A0 || ir_valid !== 1'b1)
      begin n_fail++; $display("FAIL stall_noack got pc=%h req=%b ir=%h v=%b want 0006 1 a5a0 1", pc, imem_req, ir_out, ir_valid); end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 1'b1, 16'hDEAD, 16'h0040);
    tick();
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", ir_valid); end
    n_checks++; if (imem_addr !== 16'h0040 || imem_req !== 1'b1)
      begin n_fail++; $display("FAIL redir_addr got addr=%h req=%b want 0040 1", imem_addr, imem_req); end
    drive(1'b0, 1'b0, 1'b1, 16'h0040 ^ 16'hA5A5, 16'h0041);
    tick();
    n_checks++; if (ir_out !== 16'hA5E5 || pc1_out !== 16'h0041 || ir_valid !== 1'b1)
      begin n_fail++; $display("FAIL redir_next got ir=%h pc1=%h v=%b want a5e5 0041 1", ir_out, pc1_out, ir_valid); end
    // Redirect while parked in HOLD drops the buffered word.
    drive(1'b0, 1'b1, 1'b1, 16'h7777, 16'h0042);
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0080);
    tick();
    n_checks++; if (ir_valid !== 1'b0 || pc !== 16'h0080 || imem_req !== 1'b1)
      begin n_fail++; $display("FAIL redir_hold got v=%b pc=%h req=%b want 0 0080 1", ir_valid, pc, imem_req); end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0099);
    tick();
    n_checks++; if (ir_valid !== 1'b0 || ir_out === 16'h7777)
      begin n_fail++; $display("FAIL redir_drop got v=%b ir=%h want v=0 ir!=7777", ir_valid, ir_out); end
  endtask

  task automatic test_reset_in_hold();
    drive(1'b0, 1'b1, 1'b1, 16'h5555, 16'h0081);
    tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rhold_enter got req=%b want 0", imem_req); end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 16'h5555, 16'h0090);
    tick();
    n_checks++; if (pc !== 16'h0000 || ir_out !== 16'h0000 || pc1_out !== 16'h0000 || ir_valid !== 1'b0 || imem_req !== 1'b0)
      begin n_fail++; $display("FAIL rhold_reset got pc=%h ir=%h pc1=%h v=%b req=%b want 0000 0000 0000 0 0", pc, ir_out, pc1_out, ir_valid, imem_req); end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 16'h5555, 16'h0090);
    tick();
    n_checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000)
      begin n_fail++; $display("FAIL rhold_idle got v=%b req=%b addr=%h want 0 1 0000", ir_valid, imem_req, imem_addr); end
    drive(1'b0, 1'b0, 1'b1, 16'hA5A5, 16'h0001);
    tick();
    n_checks++; if (ir_out !== 16'hA5A5 || pc1_out !== 16'h0001 || ir_valid !== 1'b1)
      begin n_fail++; $display("FAIL rhold_first got ir=%h pc1=%h v=%b want a5a5 0001 1", ir_out, pc1_out, ir_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_ack();
    test_wait_states();
    test_redirect();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
